// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the pipeline always wins the port; multi-cycle results queue in a FIFO.
// Optional WB_SCOREBOARD_EN adds a busy scoreboard with a combinational operand-hazard query.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  input  logic        mc_issue,
  input  logic [4:0]  mc_issue_rd,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        q_stall,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_wen_q, rf_wen_d;
  logic [4:0]    rf_rd_q, rf_rd_d;
  logic [31:0]   rf_data_q, rf_data_d;

  logic        pipe_eff, push, pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign pipe_eff  = pipe_wen && (pipe_rd != 5'd0);
  assign mc_ready  = (count_q < DEPTH_C);
  assign push      = mc_valid && mc_ready;
  // Pop depends only on registered count, so a fresh entry spends at least one cycle queued.
  assign pop       = (count_q != '0) && !pipe_eff;
  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rf_wen_d  = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
    if (pipe_eff) begin
      rf_wen_d  = 1'b1;
      rf_rd_d   = pipe_rd;
      rf_data_d = pipe_data;
    end else if (pop && (head_rd != 5'd0)) begin
      rf_wen_d  = 1'b1;
      rf_rd_d   = head_rd;
      rf_data_d = head_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rf_wen_q  <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rf_wen_q  <= rf_wen_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mc_rd;
      fifo_data_q[wr_ptr_q] <= mc_data;
    end
  end

  assign rf_wen  = rf_wen_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:1] busy_q, busy_d;
  logic [31:0] busy_vec;

  // Set is applied after clear so a same-cycle issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (pop && (head_rd != 5'd0)) busy_d[head_rd] = 1'b0;
    if (mc_issue && (mc_issue_rd != 5'd0)) busy_d[mc_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = {busy_q, 1'b0};
  assign q_stall  = busy_vec[q_rs1] | busy_vec[q_rs2];
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{mc_issue, mc_issue_rd, q_rs1, q_rs2};
  assign q_stall = 1'b0;
`endif

endmodule
